branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor in the fetch stage, directly upstream of the 5-stage RISC-V datapath. It pre-decodes the instruction fetched at IF and predicts B-type branches with a table of 2-bit saturating counters; JAL is always predicted taken. It drives the `pre_branch`, `prediction` and `label` redirect into the PC mux. Each prediction travels in a shadow pipeline alongside IF→ID→EX→MEM. At MEM it is resolved against the datapath's `pcsrc`, which produces `correct`, `error` and `new_label`.

## Interface
- `DATA_WIDTH`, 32, data/address width
- `BHT_ENTRIES`, 64, counter table depth; power of two; index IW = log2(BHT_ENTRIES)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pc`  in  DATA_WIDTH  current IF-stage PC
- `instr_F`  in  DATA_WIDTH  instruction fetched at `pc`
- `load_use_flag`  in  1  load-use stall from the hazard unit
- `pcsrc`  in  1  branch/jump resolved taken at MEM (datapath)
- `branch_M`  in  8  MEM-stage branch type; bits [5:0] = conditional, [6]/[7] = jumps
- `pre_branch`  out  1  `instr_F` is B-type (opcode 1100011) or JAL (1101111)
- `prediction`  out  1  predicted taken
- `label`  out  DATA_WIDTH  predicted target, `pc` + decoded immediate
- `correct`  out  1  MEM instruction was predicted taken and is taken
- `error`  out  1  MEM instruction was predicted taken but is not taken
- `new_label`  out  DATA_WIDTH  recovery PC (MEM PC + 4) when `error`, else 0
- `pred_count`  out  32  number of resolved predicted-taken instructions
- `miss_count`  out  32  number of `error` events

## Operation
- Pre-decode (combinational):
  - B immediate = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}.
  - J immediate = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  - `label` = `pc` + immediate. When `pre_branch`=0, `label` = `pc` + 4.
  - JALR is not predicted (`pre_branch`=0).
- BHT:
  - BHT_ENTRIES entries of 2-bit counters, indexed by `pc[IW+1:2]`.
  - For B-type, `prediction` = counter[1]. For JAL, `prediction` = 1. Otherwise `prediction` = 0.
- Shadow pipeline:
  - Each shadow register holds {valid, pred, is_cond, pc}. Registers are D, E and M.
  - F→D captures {pre_branch, prediction, B-type, pc}.
  - Internal `flush` = (`pcsrc` & ~`correct`) | `error`.
  - Update priority per edge: `flush` clears D, E and M valid. Otherwise `load_use_flag` holds D and clears E (bubble) while M advances. Otherwise all shift.
- Resolution at MEM (combinational from the M shadow):
  - `correct` = vM & predM & `pcsrc`.
  - `error` = vM & predM & ~`pcsrc`.
  - `new_label` = pcM + 4 when `error`.
  - When predicted not taken and taken, both outputs stay 0; the datapath's normal `pcsrc` redirect handles it.
- BHT update, on the clock edge when vM & is_condM:
  - Entry `pcM[IW+1:2]` increments (saturating at 11) if `pcsrc`, and decrements (saturating at 00) otherwise.
  - JAL never updates.
  - An IF read of the entry being updated returns the old value. The new value is visible next cycle.
- Counters:
  - `pred_count` increments when vM & predM.
  - `miss_count` increments when `error`.
  - Both wrap modulo 2^32.

## Timing
- `pre_branch`, `prediction` and `label` are valid in the same cycle as `pc` and `instr_F`.
- A prediction made at cycle t is resolved at cycle t+3, plus 1 per load-use stall cycle.
- `error`, `correct` and `new_label` are combinational from registered state and `pcsrc`. No output register is used.
- Reset (`rst`=0, async):
  - All BHT entries = 2'b01 (weakly not taken).
  - All shadow valid = 0.
  - `correct`=0, `error`=0, `new_label`=0, `pred_count`=0, `miss_count`=0.
  - Reset asserted mid-operation abandons in-flight predictions with no BHT update.
- Simultaneous events:
  - `error` with `load_use_flag`: flush wins.
  - `error` in the same cycle as a new B-type at IF: the IF prediction is outputs-only and not captured into D (wrong path).
  - Back-to-back branches in F/D/E/M are tracked independently.

## Test plan
- Reset, then fetch `beq` (instr 0x00000463) at pc 0x10 → `pre_branch`=1, `prediction`=0, `label`=0x18. Verify all counters are 0.
- Same `beq` resolved taken twice (`pcsrc`=1 at MEM, `branch_M`[0]=1) → entry 4 goes 01→10→11. The third fetch gives `prediction`=1 and `label`=0x18.
- Predicted-taken `beq` at pc 0x10 reaches MEM with `pcsrc`=0 → `error`=1, `new_label`=0x14, `miss_count`=1. D, E and M shadows are cleared on the next edge. Entry goes 11→10.
- JAL 0x008000EF at pc 0x40 → `prediction`=1, `label`=0x48. At MEM with `pcsrc`=1 → `correct`=1, `error`=0, and the BHT is unchanged.
- Branch in D while `load_use_flag`=1 for 1 cycle → D holds and E receives a bubble. Resolution comes at t+4 with correct `pcM`.
- `rst` pulsed low while a predicted branch sits in E → the shadows clear, and no `correct`/`error` appears later.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage 2-bit BHT branch predictor with shadow resolution pipeline
module branch_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instr_F,
    input  logic                  load_use_flag,
    input  logic                  pcsrc,
    input  logic [7:0]            branch_M,
    output logic                  pre_branch,
    output logic                  prediction,
    output logic [DATA_WIDTH-1:0] label,
    output logic                  correct,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] new_label,
    output logic [31:0]           pred_count,
    output logic [31:0]           miss_count
);

    localparam int IW = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [1:0] bht [BHT_ENTRIES];

    logic                  is_b;
    logic                  is_jal;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_j;
    logic [DATA_WIDTH-1:0] offset;
    logic [IW-1:0]         f_idx;

    logic                  v_d, pred_d, cond_d;
    logic                  v_e, pred_e, cond_e;
    logic                  v_m, pred_m, cond_m;
    logic [DATA_WIDTH-1:0] pc_d, pc_e, pc_m;
    logic [IW-1:0]         m_idx;
    logic                  flush;

    // The resolved branch type is carried by the shadow is_cond bit instead.
    logic unused_branch_m;
    assign unused_branch_m = ^branch_M;

    // Pre-decode of the instruction at IF
    assign is_b   = (instr_F[6:0] == OP_BRANCH);
    assign is_jal = (instr_F[6:0] == OP_JAL);
    assign imm_b  = {{(DATA_WIDTH-12){instr_F[31]}}, instr_F[7], instr_F[30:25],
                     instr_F[11:8], 1'b0};
    assign imm_j  = {{(DATA_WIDTH-20){instr_F[31]}}, instr_F[19:12], instr_F[20],
                     instr_F[30:21], 1'b0};

    always_comb begin
        offset = DATA_WIDTH'(4);
        if (is_b) begin
            offset = imm_b;
        end else if (is_jal) begin
            offset = imm_j;
        end
    end

    assign f_idx      = pc[IW+1:2];
    assign pre_branch = is_b | is_jal;
    assign prediction = is_jal | (is_b & bht[f_idx][1]);
    assign label      = pc + offset;

    // Resolution against the datapath outcome at MEM
    assign correct   = v_m & pred_m & pcsrc;
    assign error     = v_m & pred_m & ~pcsrc;
    assign flush     = (pcsrc & ~correct) | error;
    assign new_label = error ? (pc_m + DATA_WIDTH'(4)) : '0;
    assign m_idx     = pc_m[IW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_d    <= 1'b0;
            pred_d <= 1'b0;
            cond_d <= 1'b0;
            pc_d   <= '0;
            v_e    <= 1'b0;
            pred_e <= 1'b0;
            cond_e <= 1'b0;
            pc_e   <= '0;
            v_m    <= 1'b0;
            pred_m <= 1'b0;
            cond_m <= 1'b0;
            pc_m   <= '0;
        end else if (flush) begin
            // The IF instruction is on the wrong path too, so nothing is captured.
            v_d <= 1'b0;
            v_e <= 1'b0;
            v_m <= 1'b0;
        end else if (load_use_flag) begin
            v_e    <= 1'b0;
            v_m    <= v_e;
            pred_m <= pred_e;
            cond_m <= cond_e;
            pc_m   <= pc_e;
        end else begin
            v_d    <= pre_branch;
            pred_d <= prediction;
            cond_d <= is_b;
            pc_d   <= pc;
            v_e    <= v_d;
            pred_e <= pred_d;
            cond_e <= cond_d;
            pc_e   <= pc_d;
            v_m    <= v_e;
            pred_m <= pred_e;
            cond_m <= cond_e;
            pc_m   <= pc_e;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (v_m && cond_m) begin
            if (pcsrc) begin
                if (bht[m_idx] != 2'b11) begin
                    bht[m_idx] <= bht[m_idx] + 2'd1;
                end
            end else if (bht[m_idx] != 2'b00) begin
                bht[m_idx] <= bht[m_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_count <= '0;
            miss_count <= '0;
        end else begin
            if (v_m && pred_m) begin
                pred_count <= pred_count + 32'd1;
            end
            if (error) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
